// File: rtl/exu_result_buffer.sv
// In-order result buffer between the 8-bit execution unit and writeback.
// Flags are derived at capture time; architectural flags and the retire counter update on pop.
module exu_result_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [2:0]               in_sel,
  input  logic                     in_carry,
  input  logic [ADDR_W-1:0]        in_dest,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [ADDR_W-1:0]        out_dest,
  output logic [3:0]               out_flags,
  output logic [3:0]               flags_q,
  output logic [7:0]               retire_count,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // {C,N,Z,P}; carry is only meaningful for the two arithmetic opcodes
  function automatic logic [3:0] calc_flags(input logic [DATA_W-1:0] res,
                                            input logic [2:0]        sel,
                                            input logic              carry);
    logic carry_en;
    carry_en = (sel == 3'b000) || (sel == 3'b001);
    return {carry_en & carry, res[DATA_W-1], (res == {DATA_W{1'b0}}), ^res};
  endfunction

  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [ADDR_W-1:0] dest_q  [DEPTH];
  logic [3:0]        flag_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        flags_d;
  logic [7:0]        retire_q, retire_d;
  logic              push_s, pop_s;

  assign in_ready     = (count_q != CNT_W'(DEPTH));
  assign out_valid    = (count_q != {CNT_W{1'b0}});
  assign out_result   = data_q[rd_ptr_q];
  assign out_dest     = dest_q[rd_ptr_q];
  assign out_flags    = flag_q[rd_ptr_q];
  assign retire_count = retire_q;
  assign count        = count_q;

  // Next-state for pointers, occupancy, committed flags and retire counter
  always_comb begin
    push_s   = in_valid && in_ready;
    pop_s    = out_valid && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    retire_d = retire_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        flags_d  = out_flags;
        retire_d = retire_q + 8'd1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      flags_q  <= 4'b0000;
      retire_q <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      retire_q <= retire_d;
    end
  end

  // Entry storage; a flush leaves stale contents in place
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {DATA_W{1'b0}};
        dest_q[i] <= {ADDR_W{1'b0}};
        flag_q[i] <= 4'b0000;
      end
    end else if (push_s && !flush) begin
      data_q[wr_ptr_q] <= in_result;
      dest_q[wr_ptr_q] <= in_dest;
      flag_q[wr_ptr_q] <= calc_flags(in_result, in_sel, in_carry);
    end
  end

endmodule

// File: tb/tb_exu_result_buffer.sv
// Scoreboard bench for exu_result_buffer: stimulus queues hand-computed entries,
// a negedge monitor pops and compares whenever writeback accepts the head.
module tb_exu_result_buffer;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, in_carry;
  logic [7:0] in_result;
  logic [2:0] in_sel, in_dest;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [2:0] out_dest;
  logic [3:0] out_flags, flags_q;
  logic [7:0] retire_count;
  logic [2:0] count;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] dest;
    logic [3:0] f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  exu_result_buffer #(.DATA_W(8), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_sel(in_sel), .in_carry(in_carry), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_flags(out_flags), .flags_q(flags_q),
    .retire_count(retire_count), .count(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next edge when head is valid and accepted
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && !flush && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_result", 32'(out_result), 32'(e.d));
          check("out_dest",   32'(out_dest),   32'(e.dest));
          check("out_flags",  32'(out_flags),  32'(e.f));
        end
      end
    end
  end

  // Drive one result; enqueue its expectation once the buffer takes it
  task automatic push_item(input logic [7:0] d, input logic [2:0] sel, input logic c,
                           input logic [2:0] dest, input logic [3:0] f);
    bit taken = 1'b0;
    in_valid = 1'b1; in_result = d; in_sel = sel; in_carry = c; in_dest = dest;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: d, dest: dest, f: f});
        taken = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!taken) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!out_valid) break;
    end
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] conc_f [10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                              4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_result = 8'hAA;
    in_sel = 3'b000; in_carry = 1'b1; in_dest = 3'd7; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags_q", 32'(flags_q), 32'd0);
    check("rst_retire", 32'(retire_count), 32'd0);
    check("rst_out_result", 32'(out_result), 32'h00);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_count", 32'(count), 32'd0);
    mon_en = 1'b1;

    // Single pass: 0x3C has four ones
    out_ready = 1'b1;
    push_item(8'h3C, 3'b010, 1'b0, 3'd5, 4'b0000);
    drain();
    check("single_flags_q", 32'(flags_q), 32'h0);
    check("single_retire", 32'(retire_count), 32'd1);

    // Fill and backpressure
    out_ready = 1'b0;
    push_item(8'h01, 3'b010, 1'b0, 3'd1, 4'b0001);
    push_item(8'h02, 3'b011, 1'b0, 3'd2, 4'b0001);
    push_item(8'h03, 3'b100, 1'b0, 3'd3, 4'b0000);
    push_item(8'h04, 3'b101, 1'b0, 3'd4, 4'b0001);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_result = 8'h05; in_sel = 3'b010; in_carry = 1'b0; in_dest = 3'd6;
    repeat (3) @(posedge clk);
    #1;
    check("held_count", 32'(count), 32'd4);
    check("held_head", 32'(out_result), 32'h01);
    out_ready = 1'b1;
    push_item(8'h05, 3'b010, 1'b0, 3'd6, 4'b0000);
    drain();
    check("fill_retire", 32'(retire_count), 32'd6);

    // Flag derivation including carry gating by opcode
    out_ready = 1'b0;
    push_item(8'h80, 3'b100, 1'b1, 3'd0, 4'b0101);
    push_item(8'h00, 3'b000, 1'b1, 3'd1, 4'b1010);
    push_item(8'hFF, 3'b001, 1'b1, 3'd2, 4'b1100);
    push_item(8'h7F, 3'b111, 1'b1, 3'd3, 4'b0001);
    out_ready = 1'b1;
    drain();
    check("flags_flags_q", 32'(flags_q), 32'h1);
    check("flags_retire", 32'(retire_count), 32'd10);

    // Concurrent push/pop at count=2 across pointer wrap
    out_ready = 1'b0;
    push_item(8'h10, 3'b010, 1'b0, 3'd4, 4'b0001);
    push_item(8'h11, 3'b010, 1'b0, 3'd5, 4'b0000);
    check("conc_start_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_result = 8'h20 + 8'(i); in_sel = 3'b011;
      in_carry = 1'b1; in_dest = 3'(i);
      @(negedge clk);
      check("conc_count", 32'(count), 32'd2);
      if (in_ready) sb.push_back('{d: 8'h20 + 8'(i), dest: 3'(i), f: conc_f[i]});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("conc_retire", 32'(retire_count), 32'd22);

    // Retire counter wrap at 256 pops
    for (int i = 0; i < 234; i++) push_item(8'hFF, 3'b010, 1'b1, 3'd7, 4'b0100);
    drain();
    check("wrap_retire", 32'(retire_count), 32'd0);
    check("wrap_flags_q", 32'(flags_q), 32'h4);

    // Flush with simultaneous push and pop
    out_ready = 1'b0;
    push_item(8'h41, 3'b010, 1'b0, 3'd1, 4'b0000);
    push_item(8'h42, 3'b010, 1'b0, 3'd2, 4'b0000);
    push_item(8'h43, 3'b010, 1'b0, 3'd3, 4'b0001);
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_result = 8'h99; in_sel = 3'b000; in_carry = 1'b1; in_dest = 3'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_retire", 32'(retire_count), 32'd0);
    check("flush_flags_q", 32'(flags_q), 32'h4);
    out_ready = 1'b1;
    push_item(8'h5A, 3'b010, 1'b0, 3'd6, 4'b0000);
    drain();
    check("post_flush_retire", 32'(retire_count), 32'd1);
    check("post_flush_flags_q", 32'(flags_q), 32'h0);

    // Reset mid-stream discards queued entries and clears storage
    out_ready = 1'b0;
    push_item(8'hC3, 3'b001, 1'b1, 3'd2, 4'b1100);
    push_item(8'h81, 3'b000, 1'b1, 3'd3, 4'b1100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_retire", 32'(retire_count), 32'd0);
    check("mid_rst_flags_q", 32'(flags_q), 32'h0);
    check("mid_rst_out_result", 32'(out_result), 32'h00);
    check("mid_rst_out_flags", 32'(out_flags), 32'h0);
    out_ready = 1'b1;
    push_item(8'h01, 3'b010, 1'b0, 3'd1, 4'b0001);
    drain();
    check("mid_rst_retire_after", 32'(retire_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exu_result_buffer.md
Name: exu_result_buffer

Overview:
Downstream retire stage of the 8-bit execution unit. It captures each result from the logic/arithmetic units with its opcode and destination register, derives condition flags, and queues results in a small in-order FIFO with valid/ready handshakes on both sides. It commits architectural flags and counts retired operations as entries leave toward writeback.

Parameters:
DATA_W, 8, result width in bits.
ADDR_W, 3, destination register address width.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous queue clear
in_valid  in  1  upstream result valid
in_ready  out  1  buffer can accept (not full)
in_result  in  DATA_W  result from the execution unit
in_sel  in  3  opcode that produced the result; 3'b000/3'b001 arithmetic, 3'b010–3'b101 logic
in_carry  in  1  carry-out from the arithmetic unit
in_dest  in  ADDR_W  destination register
out_valid  out  1  head entry valid
out_ready  in  1  writeback accepts head
out_result  out  DATA_W  head result
out_dest  out  ADDR_W  head destination
out_flags  out  4  head flags {C,N,Z,P}
flags_q  out  4  committed architectural flags {C,N,Z,P}
retire_count  out  8  retired-operation counter, wraps
count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=1 at an edge): wr_ptr, rd_ptr, and count go to 0. All storage entries clear to 0. flags_q=0 and retire_count=0. After reset: out_valid=0, in_ready=1, and out_result/out_dest/out_flags read 0.
- Push occurs when in_valid && in_ready. The entry is stored at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Flags are computed at push time from in_result:
  - Z = (in_result==0).
  - N = in_result[DATA_W-1].
  - P = XOR-reduce of in_result (1 = odd number of ones).
  - C = in_carry when in_sel is 3'b000 or 3'b001; C = 0 for every other in_sel, including undefined codes.
- in_ready = (count != DEPTH), combinational from the registered count. There is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). The out_* fields are driven combinationally from the entry at rd_ptr.
- Latency: a value pushed at edge N appears on the outputs after edge N. There is no bypass, so an empty buffer never presents a result in the same cycle it arrives.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Full buffer: in_ready=0, so no push occurs. A pop in the same cycle leaves count=DEPTH-1; in_ready rises the next cycle.
- Empty buffer: out_valid=0, so no pop occurs. A push makes count=1.
- Upstream must hold in_result, in_sel, in_carry, and in_dest stable while in_valid=1 and in_ready=0. The buffer captures only on push.
- On pop: flags_q takes the head's out_flags, and retire_count increments (255 wraps to 0).
- flush=1 at an edge: pointers and count go to 0. Any push or pop in that cycle is discarded: no storage write, no flags_q update, no retire_count increment. flags_q and retire_count otherwise hold their values. Storage contents are not cleared.
- Priority order: rst > flush > push/pop.
- Reset asserted mid-stream discards all queued entries. The cycle after rst deasserts behaves exactly like the post-reset state.
- Pointer wrap is modulo DEPTH. count is a separate register, so full and empty are unambiguous.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, count=0, flags_q=0, retire_count=0, out_result=0x00.
- Single pass: push 0x3C, sel=3'b010, dest=5, out_ready=1 -> out_valid next cycle, out_result=0x3C, out_dest=5, out_flags={0,0,0,0}. After the pop: flags_q=0000, retire_count=1.
- Fill/backpressure: out_ready=0; push 0x01,0x02,0x03,0x04 -> count=4, in_ready=0. A held fifth value 0x05 is not taken. Set out_ready=1 -> pops return 0x01..0x04 in order, then 0x05.
- Flags/carry: push 0x80 with sel=3'b100 and in_carry=1 -> flags {C=0,N=1,Z=0,P=1}. Push 0x00 with sel=3'b000 and in_carry=1 -> {C=1,N=0,Z=1,P=0}.
- Concurrent push/pop at count=2 for 10 cycles -> count stays 2, order preserved across pointer wrap. Then 256 total pops -> retire_count wraps to 0.
- Flush at count=3 with push and pop the same cycle -> count=0, out_valid=0, retire_count and flags_q unchanged. The next push is output first.
